// File: rtl/prog_fetch_responder.sv
// prog_fetch_responder: serves CPU ROM fetches by reassembling the muxed PC and reading memory.
// Optional one-entry address cache enabled by FETCH_ADDR_CACHE_EN.
module prog_fetch_responder #(
    parameter int SETTLE_CYC  = 1,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] pc_hl,
    output logic       pc_mux,
    output logic [7:0] rom_data,
    output logic       mem_req,
    output logic [9:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       fetch_err
);
    typedef enum logic [2:0] {SET_LO, WAIT_LO, SET_HI, WAIT_HI, REQ} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic [4:0] addr_lo, addr_hi;
    logic cap_lo, cap_hi, ack, tmo, hit;

    always_comb begin
        state_nx = state;
        cap_lo   = 1'b0;
        cap_hi   = 1'b0;
        ack      = 1'b0;
        tmo      = 1'b0;
        pc_mux   = (state == SET_HI) || (state == WAIT_HI);
        mem_req  = (state == REQ);
        case (state)
            SET_LO:  state_nx = WAIT_LO;
            WAIT_LO: if (cnt == 8'(SETTLE_CYC - 1)) begin
                cap_lo   = 1'b1;
                state_nx = SET_HI;
            end
            SET_HI:  state_nx = WAIT_HI;
            WAIT_HI: if (cnt == 8'(SETTLE_CYC - 1)) begin
                cap_hi   = 1'b1;
                state_nx = hit ? SET_LO : REQ;
            end
            REQ: if (mem_ack) begin
                ack      = 1'b1;
                state_nx = SET_LO;
            end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
                tmo      = 1'b1;
                state_nx = SET_LO;
            end
            default: state_nx = SET_LO;
        endcase
    end

    // counter restarts on every state entry and saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SET_LO;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 8'(cnt != '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo   <= '0;
            addr_hi   <= '0;
            rom_data  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (cap_lo) addr_lo <= pc_hl;
            if (cap_hi) addr_hi <= pc_hl;
            if (ack) rom_data <= mem_rdata;
            else if (tmo) rom_data <= '0;
            if (tmo) fetch_err <= 1'b1;
        end
    end

    assign mem_addr = {addr_hi, addr_lo};

`ifdef FETCH_ADDR_CACHE_EN
    logic       cache_v;
    logic [9:0] cache_addr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_v    <= 1'b0;
            cache_addr <= '0;
        end else if (ack) begin
            cache_v    <= 1'b1;
            cache_addr <= mem_addr;
        end else if (tmo) begin
            cache_v    <= 1'b0;
        end
    end
    // compare against the address about to be assembled at the high capture
    assign hit = cache_v && ({pc_hl, addr_lo} == cache_addr);
`else
    assign hit = 1'b0;
`endif
endmodule

// File: tb/tb_prog_fetch_responder.sv
// tb_prog_fetch_responder: directed and random fetch traffic checked every cycle against a loop-position model.
module tb_prog_fetch_responder;
    localparam int S = 1;
    localparam int T = 15;
`ifdef FETCH_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] pc_hl = '0;
    logic       pc_mux;
    logic [7:0] rom_data;
    logic       mem_req;
    logic [9:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic       fetch_err;

    prog_fetch_responder #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .pc_hl(pc_hl), .pc_mux(pc_mux), .rom_data(rom_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus controls
    bit         rnd_pc = 1'b1;
    bit         rnd_data = 1'b0;
    bit         ack_rand = 1'b1;
    bit         hold_ack = 1'b0;
    int         ack_at = 0;
    int         req_cnt = 0;
    logic [9:0] pc = '0;
    logic [7:0] rdata_v = '0;

    // CPU side: present the half of pc selected by pc_mux; memory side: ack on a chosen REQ cycle
    always @(posedge clk) begin
        #2;
        req_cnt   = mem_req ? req_cnt + 1 : 0;
        pc_hl     = rnd_pc ? 5'($urandom) : (pc_mux ? pc[9:5] : pc[4:0]);
        mem_rdata = rnd_data ? 8'($urandom) : rdata_v;
        if (!hold_ack)
            mem_ack = ack_rand ? ($urandom_range(0, 7) == 0) : (mem_req && req_cnt == ack_at);
    end

    // model: position within the fetch loop plus the architecturally visible registers
    int         pos = 0;
    logic [4:0] m_lo = '0, m_hi = '0;
    logic [7:0] m_rom = '0;
    bit         m_err = 1'b0, m_cv = 1'b0;
    logic [9:0] m_ca = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            pos = 0; m_lo = '0; m_hi = '0; m_rom = '0; m_err = 1'b0; m_cv = 1'b0; m_ca = '0;
        end else if (pos == S) begin
            m_lo = pc_hl;
            pos++;
        end else if (pos == 2 * S + 1) begin
            m_hi = pc_hl;
            pos = (CACHE && m_cv && {m_hi, m_lo} == m_ca) ? 0 : pos + 1;
        end else if (pos >= 2 * S + 2) begin
            if (mem_ack) begin
                m_rom = mem_rdata; m_cv = 1'b1; m_ca = {m_hi, m_lo}; pos = 0;
            end else if (pos - (2 * S + 1) == T) begin
                m_rom = '0; m_err = 1'b1; m_cv = 1'b0; pos = 0;
            end else begin
                pos++;
            end
        end else begin
            pos++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_pc_mux", pc_mux, 0);
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_rom_data", rom_data, 0);
            chk("rst_fetch_err", fetch_err, 0);
        end else begin
            chk("pc_mux", pc_mux, (pos >= S + 1 && pos <= 2 * S + 1));
            chk("mem_req", mem_req, (pos >= 2 * S + 2));
            chk("mem_addr", mem_addr, {m_hi, m_lo});
            chk("rom_data", rom_data, m_rom);
            chk("fetch_err", fetch_err, m_err);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    // run until one REQ phase has completed; returns how many cycles mem_req was high
    task automatic wait_req(output int hi);
        int n;
        hi = 0;
        n = 0;
        while (!mem_req && n < 60) begin cyc(); n++; end
        while (mem_req && n < 60) begin cyc(); hi++; n++; end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL wait_req: no completed request within 60 cycles");
        end
    endtask

    int hi;
    int pulses;
    bit prev;

    initial begin
        #1 rst_n = 1'b0;
        repeat (6) cyc();
        chk("reset_mem_req_lit", mem_req, 0);
        chk("reset_rom_lit", rom_data, 8'h00);

        rnd_pc = 1'b0; ack_rand = 1'b0; pc = 10'h175; ack_at = 2; rdata_v = 8'hC3;
        cyc();
        rst_n = 1'b1;
        wait_req(hi);
        chk("addr_lit", mem_addr, 10'h175);
        chk("addr_req_len", hi, 2);
        chk("addr_rom_lit", rom_data, 8'hC3);

        pc = 10'h0C7; ack_at = 15; rdata_v = 8'h5E;
        wait_req(hi);
        chk("coll_req_len", hi, 15);
        chk("coll_rom_lit", rom_data, 8'h5E);
        chk("coll_err_lit", fetch_err, 0);

        pc = 10'h3FF; ack_at = 0;
        wait_req(hi);
        chk("tmo_req_len", hi, 15);
        chk("tmo_rom_lit", rom_data, 8'h00);
        chk("tmo_err_lit", fetch_err, 1);
        ack_at = 2; rdata_v = 8'hA5;
        wait_req(hi);
        chk("tmo_err_sticky", fetch_err, 1);
        chk("after_tmo_rom", rom_data, 8'hA5);

        pc = 10'h2A3; rdata_v = 8'h77;
        pulses = 0;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (mem_req && !prev) pulses++;
            prev = mem_req;
        end
        chk("cache_pulses", pulses, CACHE ? 1 : 2);
        chk("cache_rom", rom_data, 8'h77);

        pc = 10'h155; ack_at = 0;
        for (int n = 0; n < 60 && !mem_req; n++) cyc();
        chk("midreq_seen", mem_req, 1);
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("midreq_drop", mem_req, 0);
        hold_ack = 1'b1;
        cyc();
        cyc();
        mem_ack = 1'b1;
        rdata_v = 8'hEE;
        cyc();
        chk("midreq_req", mem_req, 0);
        chk("midreq_rom", rom_data, 8'h00);
        mem_ack = 1'b0;
        hold_ack = 1'b0;
        cyc();
        rst_n = 1'b1;

        rnd_pc = 1'b1; rnd_data = 1'b1; ack_rand = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                cyc();
                cyc();
                rst_n = 1'b1;
            end
        end
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
